// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: the decoder/LUT/imem-facing bundle of the fetch-stage PC
// controller.
//   slave  : the sequencer. It takes start/stall/halt/branch controls and
//            lut_target, and drives lut_addr, pc, fetch, done and instr_count.
//   master : the decoder/bench side, the mirror image of slave.
// PC_W and CNT_W must match the parameters of the sequencer that is attached.
interface pc_sequencer_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stall;
  logic             halt;
  logic             branch_en;
  logic             branch_cond;
  logic             rel_mode;
  logic [2:0]       lut_idx;
  logic [2:0]       lut_addr;
  logic [PC_W-1:0]  lut_target;
  logic [PC_W-1:0]  pc;
  logic             fetch;
  logic             done;
  logic [CNT_W-1:0] instr_count;

  modport slave (
    input  start, stall, halt, branch_en, branch_cond, rel_mode, lut_idx, lut_target,
    output lut_addr, pc, fetch, done, instr_count
  );

  modport master (
    output start, stall, halt, branch_en, branch_cond, rel_mode, lut_idx, lut_target,
    input  lut_addr, pc, fetch, done, instr_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter controller for the 9-bit processor's fetch stage.
// It runs an IDLE/RUN/DONE state machine, advances or branches the PC, steers
// the branch-target LUT index, and keeps a saturating retired-instruction count.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : pc_sequencer_if.slave, carrying the decoder controls, the LUT
//          address and target, and the pc/fetch/done/instr_count outputs
module pc_sequencer #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  pc_sequencer_if.slave    bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // A stalled cycle retires nothing. The decoder re-presents the same
        // controls, so they can be ignored here.
        if (!bus.stall) begin
          // The halt instruction itself counts as retired.
          cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
          if (bus.halt) begin
            state_d = DONE;
          end else if (bus.branch_en && bus.branch_cond) begin
            // The relative target is two's complement, so a plain modular
            // add gives the signed offset.
            pc_d = bus.rel_mode ? pc_q + bus.lut_target : bus.lut_target;
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.lut_addr    = bus.lut_idx;
  assign bus.pc          = pc_q;
  assign bus.fetch       = (state_q == RUN) && !bus.stall;
  assign bus.done        = (state_q == DONE);
  assign bus.instr_count = cnt_q;
endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter controller for the 9-bit processor's fetch stage. It holds the current instruction address, advances it each cycle, and resolves branches by steering the 3-bit branch-target LUT index and consuming the 10-bit target the LUT returns. It also owns the run/halt state machine and a retired-instruction counter. It sits between the instruction decoder (branch/halt/stall controls) and instruction memory (address output).

## Interface

Parameters:
- PC_W, 10, program counter and LUT target width
- CNT_W, 16, retired-instruction counter width

Ports:
- Clk  input  1  system clock; all state updates on rising edge
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  begin execution from address 0; honoured only in IDLE or DONE
- Stall  input  1  freeze PC and counter for this cycle
- Halt  input  1  decoded halt instruction at current PC
- BranchEn  input  1  decoded branch instruction at current PC
- BranchCond  input  1  branch condition flag; taken = BranchEn & BranchCond
- RelMode  input  1  1: target is signed PC-relative offset; 0: absolute address
- LutIdx  input  3  branch-target selector from the instruction
- LutAddr  output  3  address to the target LUT
- LutTarget  input  PC_W  target returned by the LUT (combinational)
- PC  output  PC_W  current instruction address
- Fetch  output  1  PC is a valid fetch address this cycle
- Done  output  1  program has halted
- InstrCount  output  CNT_W  retired-instruction count, saturating

## Operation

- LutAddr = LutIdx, combinational, in every state; the LUT is pure combinational, so LutTarget is consumed in the same cycle.
- States:
  - IDLE: reset state.
  - RUN: executing.
  - DONE: halted.
- Transitions:
  - IDLE --Start--> RUN.
  - RUN --(Halt & ~Stall)--> DONE.
  - DONE --Start--> RUN.
  - Start in RUN is ignored.
- Entering RUN from IDLE or DONE: PC <= 0, InstrCount <= 0.
- Each RUN cycle with Stall=0, priority order:
  1. Halt: PC holds, go to DONE.
  2. Taken branch, RelMode=0: PC <= LutTarget.
  3. Taken branch, RelMode=1: PC <= PC + LutTarget (LutTarget is two's complement), modulo 2^PC_W.
  4. Otherwise: PC <= PC + 1, modulo 2^PC_W (0x3FF wraps to 0x000).
- Halt and BranchEn asserted together: Halt wins and the branch is discarded.
- BranchEn=1 with BranchCond=0: PC <= PC + 1.
- Stall=1 in RUN: PC, state and InstrCount hold; Halt and branch inputs are ignored, and the decoder re-presents them.
- InstrCount increments by 1 for each RUN cycle with Stall=0, including the halt instruction. It saturates at 2^CNT_W-1 and never wraps.
- In IDLE and DONE, Stall, Halt and branch inputs are ignored.

## Timing

- Reset values:
  - state IDLE, PC=0, InstrCount=0.
  - Fetch=0, Done=0.
  - LutAddr tracks LutIdx through reset.
- Reset asserted mid-RUN: all outputs return to their reset values immediately (asynchronous). Operation resumes only after Reset deasserts and Start is seen.
- Fetch = (state==RUN) & ~Stall, combinational.
- Done = (state==DONE), registered; it rises on the edge that retires the halt.
- Start-to-first-fetch latency is 1 cycle: Start sampled at edge N, then PC=0 and Fetch=1 after edge N.
- Branch resolution has 0 bubbles: the new PC is visible the cycle after the branch is presented.
- Start and Reset asserted together: Reset wins.
- PC is always registered. The only combinational paths are LutIdx->LutAddr and (state, Stall)->Fetch.

## Test plan

- Reset/start:
  - Hold Reset, then release: expect PC=0, Fetch=0, Done=0, InstrCount=0.
  - Pulse Start: next cycle expect PC=0, Fetch=1; PC then counts 1, 2, 3.
- Absolute branch:
  - At PC=0x005, drive BranchEn=1, BranchCond=1, RelMode=0, LutIdx=2, LutTarget=0x1F0: expect LutAddr=2 the same cycle and PC=0x1F0 the next.
  - Repeat with BranchCond=0: expect PC=0x006.
- Relative branch and wrap:
  - At PC=0x020, RelMode=1, LutTarget=0x3F0 (-16): expect PC=0x010.
  - At PC=0x3FF with no branch: expect PC=0x000.
- Stall and priority:
  - Stall=1 for 3 cycles at PC=0x010 with BranchEn=1: expect PC and InstrCount frozen, Fetch=0, branch ignored.
  - Halt=1 with BranchEn=1: expect PC holds, Done=1 next cycle, and InstrCount incremented by exactly 1.
- Restart and reset mid-run:
  - From DONE, pulse Start: expect PC=0, InstrCount=0, Done=0.
  - Assert Reset asynchronously mid-RUN, between clock edges: expect PC=0 and Fetch=0 before the next edge.
- Counter saturation (bench overrides CNT_W=4): run 20 unstalled cycles: expect InstrCount to stop at 15.
